tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4:1 select/mux path. It accepts one sample per valid cycle from a serialized stream, with slot 0 marked by a frame-start flag. It steers the samples into channels 0-3 and presents a complete, coherent frame on four registered outputs with a one-cycle frame strobe. It sits downstream of the 4:1 multiplexer (or any TDM serializer driving slots 0,1,2,3 in order) and restores the parallel D0-D3 view.

## Interface
- WIDTH, 1, bits per channel sample
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  serialized sample
- din_valid  input  1  din carries a sample this cycle
- frame_start  input  1  qualifies din as slot 0; ignored when din_valid=0
- Q0, Q1, Q2, Q3  output  WIDTH each  demuxed channel data of the last complete frame, registered
- frame_valid  output  1  one-cycle pulse: Q0-Q3 just updated with a new frame
- slot  output  2  next slot expected (S1,S0 equivalent); 0 in IDLE
- frame_err  output  1  one-cycle pulse: frame_start arrived mid-frame and the partial frame was dropped

## Operation
- Reset (async assert, sync release): state=IDLE, slot=0, shadow regs=0, Q0-Q3=0, frame_valid=0, frame_err=0.
- Shadow regs sh0-sh2 hold slots 0-2 of the frame in progress. Q0-Q3 change only on frame completion, so a frame is never shown torn.
- FSM states: IDLE and COLLECT.
- IDLE, din_valid & frame_start: sh0<=din, slot<=1, go to COLLECT.
- IDLE, din_valid & !frame_start: sample discarded, stay in IDLE. There is no error; this is the resync behaviour.
- COLLECT, din_valid & !frame_start, slot 1 or 2: sh[slot]<=din, slot<=slot+1.
- COLLECT, din_valid & !frame_start, slot 3: Q0<=sh0, Q1<=sh1, Q2<=sh2, Q3<=din, frame_valid<=1, slot<=0, go to IDLE.
- COLLECT, din_valid & frame_start, any slot: frame_err<=1, partial frame dropped (Q unchanged), sh0<=din, slot<=1, stay in COLLECT.
- din_valid=0: all state holds. Gaps of any length between samples are legal.
- frame_valid and frame_err are never both 1 in the same cycle.
- slot never exceeds 3. There is no wrap inside COLLECT; the only path from slot 3 back to 0 is frame completion.

## Timing
- Frame latency: Q0-Q3 and frame_valid update on the same edge that samples the slot-3 din. Both are visible in the following cycle.
- frame_valid is high for exactly one cycle. It clears on the next edge unconditionally.
- Back-to-back frames: a frame_start sample in the cycle right after completion is accepted from IDLE with no bubble. Sustained throughput is 1 frame per 4 valid cycles.
- frame_err is high for exactly one cycle, in the cycle after the offending edge.
- Reset mid-frame: outputs and state clear asynchronously. The partial frame is lost, with no frame_valid and no frame_err.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package tdm_pkg holds:
  - NUM_CH = 4
  - typedef slot_t = logic [1:0]
  - typedef enum {IDLE, COLLECT} tdm_state_t
- Sub-module tdm_frame_reg(WIDTH): the sh0-sh2 shadow bank plus the Q0-Q3 output bank, with load-slot and commit controls. The FSM and slot counter stay in tdm_demux4.

## Test plan
- Reset: hold rst_n=0, drive random din/valid -> Q0-Q3=0, slot=0, frame_valid=0, frame_err=0. Release rst_n -> nothing changes until a frame_start sample arrives.
- Basic frame, WIDTH=4: valid samples 0xA(fs=1), 0xB, 0xC, 0xD on consecutive cycles -> cycle after the 4th edge shows Q0=A, Q1=B, Q2=C, Q3=D and frame_valid=1 for one cycle; slot reads 1,2,3,0.
- Gaps and back-to-back: insert din_valid=0 gaps of 0-3 cycles between samples, then start frame 2 (1,2,3,4) in the cycle right after frame 1 completes -> both frames correct, exactly two frame_valid pulses, Q stable during gaps.
- Mid-frame restart: 0x1(fs), 0x2, then 0x7(fs), 0x8, 0x9, 0xA -> frame_err pulse after the 0x7 edge; Q0-Q3 = 7,8,9,A; no frame_valid for the dropped frame.
- Resync: valid samples without frame_start while in IDLE -> ignored, slot stays 0, no strobes. A following fs frame decodes correctly.
- Reset mid-frame: assert rst_n=0 after slot 2 -> immediate clear, no strobe. After release, a new full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serialized-input / parallel-output bundle for tdm_demux4.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
);
  import tdm_pkg::*;

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_start;
  logic [WIDTH-1:0] Q0;
  logic [WIDTH-1:0] Q1;
  logic [WIDTH-1:0] Q2;
  logic [WIDTH-1:0] Q3;
  logic             frame_valid;
  slot_t            slot;
  logic             frame_err;

  modport master (
    output din, din_valid, frame_start,
    input  Q0, Q1, Q2, Q3, frame_valid, slot, frame_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output Q0, Q1, Q2, Q3, frame_valid, slot, frame_err
  );
endinterface

// File: rtl/tdm_demux4_frame_reg.sv
// Shadow bank for slots 0-2 of the frame in progress, plus the output bank
// that is only written on commit so a frame is never shown torn.
module tdm_frame_reg
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_en,
  input  slot_t            load_slot,
  input  logic             commit,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3
);

  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      q0  <= '0;
      q1  <= '0;
      q2  <= '0;
      q3  <= '0;
    end else begin
      if (load_en) begin
        case (load_slot)
          2'd0:    sh0 <= din;
          2'd1:    sh1 <= din;
          2'd2:    sh2 <= din;
          default: ;
        endcase
      end
      // Slot 3 bypasses the shadow bank and goes straight into q3.
      if (commit) begin
        q0 <= sh0;
        q1 <= sh1;
        q2 <= sh2;
        q3 <= din;
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: slot FSM steering a serialized stream into
// a coherent registered frame with frame_valid / frame_err strobes.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  tdm_state_t state;
  slot_t      slot;
  logic       frame_valid;
  logic       frame_err;

  logic       last_slot;
  logic       load_en;
  slot_t      load_slot;
  logic       commit;

  always_comb begin
    last_slot = (slot == slot_t'(NUM_CH - 1));
    load_en   = 1'b0;
    load_slot = slot;
    commit    = 1'b0;
    if (bus.din_valid) begin
      if (bus.frame_start) begin
        load_en   = 1'b1;
        load_slot = '0;
      end else if (state == COLLECT) begin
        load_en = !last_slot;
        commit  = last_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          IDLE: begin
            if (bus.frame_start) begin
              slot  <= 2'd1;
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (bus.frame_start) begin
              frame_err <= 1'b1;
              slot      <= 2'd1;
            end else if (last_slot) begin
              frame_valid <= 1'b1;
              slot        <= '0;
              state       <= IDLE;
            end else begin
              slot <= slot + 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  tdm_frame_reg #(.WIDTH(WIDTH)) u_frame_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (bus.din),
    .load_en   (load_en),
    .load_slot (load_slot),
    .commit    (commit),
    .q0        (bus.Q0),
    .q1        (bus.Q1),
    .q2        (bus.Q2),
    .q3        (bus.Q3)
  );

  assign bus.slot        = slot;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_err   = frame_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 at WIDTH=4.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(4)) bus ();

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  int fe_cnt   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mq = '0;
  logic [3:0]  msh[3];
  int unsigned mslot = 0;
  bit          mcoll = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] frame_q();
    return {bus.Q0, bus.Q1, bus.Q2, bus.Q3};
  endfunction

  // Frame checker: every frame_valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (bus.frame_valid) begin
      fv_cnt++;
      if (exp_q.size() == 0) check("sb_unexpected_frame", 32'd1, 32'd0);
      else check("sb_frame", {16'd0, frame_q()}, {16'd0, exp_q.pop_front()});
    end
    if (bus.frame_err) fe_cnt++;
  end

  task automatic step(input bit v, input logic [3:0] d, input bit fs);
    bit efv;
    bit efe;
    efv = 1'b0;
    efe = 1'b0;
    @(negedge clk);
    bus.din_valid   = v;
    bus.din         = d;
    bus.frame_start = fs;
    if (v) begin
      if (fs) begin
        efe     = mcoll;
        msh[0]  = d;
        mslot   = 1;
        mcoll   = 1'b1;
      end else if (mcoll) begin
        if (mslot == 3) begin
          mq = {msh[0], msh[1], msh[2], d};
          exp_q.push_back(mq);
          efv   = 1'b1;
          mslot = 0;
          mcoll = 1'b0;
        end else begin
          msh[mslot] = d;
          mslot++;
        end
      end
    end
    @(posedge clk);
    #1;
    check("slot", {30'd0, bus.slot}, mslot);
    check("frame_valid", {31'd0, bus.frame_valid}, {31'd0, efv});
    check("frame_err", {31'd0, bus.frame_err}, {31'd0, efe});
    if (!efv) check("q_hold", {16'd0, frame_q()}, {16'd0, mq});
  endtask

  task automatic send_frame(input logic [15:0] f);
    step(1'b1, f[15:12], 1'b1);
    step(1'b1, f[11:8],  1'b0);
    step(1'b1, f[7:4],   1'b0);
    step(1'b1, f[3:0],   1'b0);
  endtask

  initial begin
    int fv0;
    int fe0;
    logic [15:0] g;
    bus.din_valid   = 1'b0;
    bus.din         = '0;
    bus.frame_start = 1'b0;

    // Reset held with random traffic on the inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.din_valid   = 1'($urandom_range(0, 1));
      bus.din         = 4'($urandom_range(0, 15));
      bus.frame_start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_q", {16'd0, frame_q()}, 32'd0);
      check("rst_slot", {30'd0, bus.slot}, 32'd0);
      check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
      check("rst_fe", {31'd0, bus.frame_err}, 32'd0);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);

    // Basic frame A,B,C,D
    send_frame(16'hABCD);
    step(1'b0, 4'h0, 1'b0);

    // Gapped frame followed immediately by a back-to-back frame
    fv0 = fv_cnt;
    g = 16'h356E;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, g[15-4*i -: 4], i == 0);
      if (i < 3) repeat (i + 1) step(1'b0, 4'hF, 1'b0);
    end
    send_frame(16'h1234);
    step(1'b0, 4'h0, 1'b0);
    check("b2b_pulses", fv_cnt - fv0, 32'd2);

    // Mid-frame restart drops the partial frame
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b0);
    send_frame(16'h789A);
    step(1'b0, 4'h0, 1'b0);
    check("restart_err_pulses", fe_cnt - fe0, 32'd1);
    check("restart_fv_pulses", fv_cnt - fv0, 32'd1);
    check("restart_q", {16'd0, frame_q()}, 32'h789A);

    // Resync: unflagged samples in IDLE are ignored
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    send_frame(16'hF012);

    // Asynchronous reset after slot 2
    step(1'b1, 4'h4, 1'b1);
    step(1'b1, 4'h5, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", {16'd0, frame_q()}, 32'd0);
    check("mid_rst_slot", {30'd0, bus.slot}, 32'd0);
    check("mid_rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    mq    = '0;
    mslot = 0;
    mcoll = 1'b0;
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    send_frame(16'h9876);
    step(1'b0, 4'h0, 1'b0);

    check("total_frames", fv_cnt, 32'd6);
    check("total_errs", fe_cnt, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
